// File: rtl/instr_fetch_decode_pkg.sv
// Shared CPU definitions: major opcodes, R-type ext codes, ALU opcodes, flag
// indices, branch condition codes and fetch/decode FSM state encoding.
package instr_fetch_decode_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_ADDUI = 4'h6;
  localparam logic [3:0] OP_ADDCI = 4'h7;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] EXT_NOP = 4'h0;
  localparam logic [3:0] EXT_CMP = 4'hB;

  localparam logic [7:0] ALU_NOP = 8'h00;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_N = 4;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_FS = 4'h4;
  localparam logic [3:0] COND_FC = 4'h5;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  function automatic logic cond_met(input logic [3:0] cond, input logic [4:0] flags);
    case (cond)
      COND_EQ: cond_met = flags[FLAG_Z];
      COND_NE: cond_met = !flags[FLAG_Z];
      COND_CS: cond_met = flags[FLAG_C];
      COND_CC: cond_met = !flags[FLAG_C];
      COND_FS: cond_met = flags[FLAG_F];
      COND_FC: cond_met = !flags[FLAG_F];
      COND_LO: cond_met = flags[FLAG_L];
      COND_HS: cond_met = !flags[FLAG_L];
      COND_LT: cond_met = flags[FLAG_N];
      COND_GE: cond_met = !flags[FLAG_N];
      COND_UC: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction memory bus, data_path flags and data_path control signals.
interface instr_fetch_decode_if #(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int SEL_WIDTH    = 4,
  parameter int ADDR_WIDTH   = 10
);
  logic [FLAG_WIDTH-1:0]   Flags;
  logic [BIT_WIDTH-1:0]    Mem_rdata;
  logic [ADDR_WIDTH-1:0]   Mem_addr;
  logic                    Mem_rd_en;
  logic [SEL_WIDTH-1:0]    Rsrc_mux_sel;
  logic [SEL_WIDTH-1:0]    Rdest_mux_sel;
  logic                    Imm_mux_sel;
  logic [BIT_WIDTH-1:0]    Imm_val;
  logic [OPCODE_WIDTH-1:0] Opcode;
  logic [BIT_WIDTH-1:0]    Reg_File_En;
  logic                    Halted;
  logic                    Illegal;

  modport master (
    input  Flags, Mem_rdata,
    output Mem_addr, Mem_rd_en, Rsrc_mux_sel, Rdest_mux_sel, Imm_mux_sel,
           Imm_val, Opcode, Reg_File_En, Halted, Illegal
  );

  modport slave (
    output Flags, Mem_rdata,
    input  Mem_addr, Mem_rd_en, Rsrc_mux_sel, Rdest_mux_sel, Imm_mux_sel,
           Imm_val, Opcode, Reg_File_En, Halted, Illegal
  );
endinterface

// File: rtl/instr_fetch_decode_decode.sv
// Combinational instruction decoder: IR + flags -> data_path controls,
// branch decision, halt and illegal-opcode indications.
module instr_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int SEL_WIDTH    = 4
) (
  input  logic [BIT_WIDTH-1:0]    i_ir,
  input  logic [FLAG_WIDTH-1:0]   i_flags,
  output logic [SEL_WIDTH-1:0]    o_rsrc,
  output logic [SEL_WIDTH-1:0]    o_rdest,
  output logic                    o_imm_sel,
  output logic [BIT_WIDTH-1:0]    o_imm_val,
  output logic [OPCODE_WIDTH-1:0] o_opcode,
  output logic [BIT_WIDTH-1:0]    o_reg_en,
  output logic                    o_taken,
  output logic                    o_halt,
  output logic                    o_illegal
);
  logic [3:0]        w_op;
  logic [3:0]        w_dst;
  logic [3:0]        w_ext;
  logic [3:0]        w_src;
  logic signed [7:0] w_imm8;
  logic              w_write;

  assign w_op   = i_ir[15:12];
  assign w_dst  = i_ir[11:8];
  assign w_ext  = i_ir[7:4];
  assign w_src  = i_ir[3:0];
  assign w_imm8 = i_ir[7:0];

  always_comb begin
    o_rsrc    = '0;
    o_rdest   = '0;
    o_imm_sel = 1'b0;
    o_imm_val = '0;
    o_opcode  = '0;
    o_reg_en  = '0;
    o_taken   = 1'b0;
    o_halt    = 1'b0;
    o_illegal = 1'b0;
    w_write   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        o_rsrc   = SEL_WIDTH'(w_src);
        o_rdest  = SEL_WIDTH'(w_dst);
        o_opcode = OPCODE_WIDTH'({4'h0, w_ext});
        w_write  = (w_ext != EXT_NOP) && (w_ext != EXT_CMP);
      end
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: begin
        o_rsrc    = SEL_WIDTH'(w_dst);
        o_rdest   = SEL_WIDTH'(w_dst);
        o_imm_sel = 1'b1;
        o_imm_val = BIT_WIDTH'(w_imm8);
        o_opcode  = OPCODE_WIDTH'({w_op, 4'h0});
        w_write   = (w_op != OP_CMPI);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDUI, OP_MOVI: begin
        o_rsrc    = SEL_WIDTH'(w_dst);
        o_rdest   = SEL_WIDTH'(w_dst);
        o_imm_sel = 1'b1;
        o_imm_val = BIT_WIDTH'(i_ir[7:0]);
        o_opcode  = OPCODE_WIDTH'({w_op, 4'h0});
        w_write   = 1'b1;
      end
      // Shift amount travels on Imm_val while the ALU still reads the register path
      OP_SHIFT: begin
        o_rsrc    = SEL_WIDTH'(w_dst);
        o_rdest   = SEL_WIDTH'(w_dst);
        o_imm_val = BIT_WIDTH'(w_src);
        o_opcode  = OPCODE_WIDTH'({OP_SHIFT, w_ext});
        w_write   = 1'b1;
      end
      OP_BCOND: o_taken = cond_met(w_dst, 5'(i_flags));
      OP_HALT:  o_halt  = 1'b1;
      default:  o_illegal = 1'b1;
    endcase
    if (w_write) o_reg_en = BIT_WIDTH'(1) << w_dst;
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Three-cycle fetch/wait/execute controller driving data_path from a
// synchronous instruction memory; owns the PC, IR and FSM.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int SEL_WIDTH    = 4,
  parameter int ADDR_WIDTH   = 10,
  parameter int RESET_PC     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_decode_if.master bus
);
  logic [1:0]             r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [BIT_WIDTH-1:0]   r_ir;

  logic [SEL_WIDTH-1:0]    w_rsrc, w_rdest;
  logic                    w_imm_sel, w_taken, w_halt, w_illegal, w_exec;
  logic [BIT_WIDTH-1:0]    w_imm_val, w_reg_en;
  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic signed [7:0]       w_disp;
  logic [ADDR_WIDTH-1:0]   w_pc_next;

  instr_decode #(
    .BIT_WIDTH(BIT_WIDTH), .OPCODE_WIDTH(OPCODE_WIDTH),
    .FLAG_WIDTH(FLAG_WIDTH), .SEL_WIDTH(SEL_WIDTH)
  ) u_decode (
    .i_ir(r_ir), .i_flags(bus.Flags),
    .o_rsrc(w_rsrc), .o_rdest(w_rdest), .o_imm_sel(w_imm_sel),
    .o_imm_val(w_imm_val), .o_opcode(w_opcode), .o_reg_en(w_reg_en),
    .o_taken(w_taken), .o_halt(w_halt), .o_illegal(w_illegal)
  );

  // Branch displacement is relative to the branch's own address; wrap is silent
  assign w_disp    = r_ir[7:0];
  assign w_pc_next = w_taken ? r_pc + ADDR_WIDTH'(w_disp) : r_pc + ADDR_WIDTH'(1);
  assign w_exec    = (r_state == S_EXEC);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= ADDR_WIDTH'(RESET_PC);
      r_ir    <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_ir    <= bus.Mem_rdata;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_halt) begin
            r_state <= S_HALT;
          end else begin
            r_pc    <= w_pc_next;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign bus.Mem_addr      = r_pc;
  assign bus.Mem_rd_en     = (r_state == S_FETCH);
  assign bus.Rsrc_mux_sel  = w_exec ? w_rsrc    : '0;
  assign bus.Rdest_mux_sel = w_exec ? w_rdest   : '0;
  assign bus.Imm_mux_sel   = w_exec & w_imm_sel;
  assign bus.Imm_val       = w_exec ? w_imm_val : '0;
  assign bus.Opcode        = w_exec ? w_opcode  : OPCODE_WIDTH'(ALU_NOP);
  assign bus.Reg_File_En   = w_exec ? w_reg_en  : '0;
  assign bus.Halted        = (r_state == S_HALT);
  assign bus.Illegal       = w_exec & w_illegal;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode with a synchronous instruction memory model.
module tb_instr_fetch_decode;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] mem_q = '0;
  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_decode_if #(.ADDR_WIDTH(AW)) bus ();

  instr_fetch_decode #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.Mem_rd_en) mem_q <= mem[bus.Mem_addr];
  assign bus.Mem_rdata = mem_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From an S_FETCH sample point to the matching S_EXEC sample point
  task automatic to_exec();
    tick();
    tick();
  endtask

  task automatic nop_run(input int n);
    for (int i = 0; i < n; i++) begin
      to_exec();
      tick();
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic any_rd;
    logic any_unhalt;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    mem[0] = 16'hD07F;
    mem[1] = 16'h0251;
    mem[2] = 16'h00B1;
    mem[3] = 16'h94FF;
    mem[4] = 16'h13FF;
    mem[5] = 16'h8312;
    bus.Flags = 5'b00000;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_rd_en", 32'(bus.Mem_rd_en), 32'd1);
    chk("rst_addr", 32'(bus.Mem_addr), 32'd0);
    chk("rst_halted", 32'(bus.Halted), 32'd0);
    chk("rst_illegal", 32'(bus.Illegal), 32'd0);
    chk("rst_opcode", 32'(bus.Opcode), 32'h00);
    chk("rst_en", 32'(bus.Reg_File_En), 32'h0);

    // MOVI R0,0x7F
    tick();
    chk("wait_rd_en", 32'(bus.Mem_rd_en), 32'd0);
    chk("wait_opcode", 32'(bus.Opcode), 32'h00);
    tick();
    chk("movi_opcode", 32'(bus.Opcode), 32'hD0);
    chk("movi_imm", 32'(bus.Imm_val), 32'h007F);
    chk("movi_isel", 32'(bus.Imm_mux_sel), 32'd1);
    chk("movi_rdest", 32'(bus.Rdest_mux_sel), 32'd0);
    chk("movi_en", 32'(bus.Reg_File_En), 32'h0001);
    tick();
    chk("movi_next", 32'(bus.Mem_addr), 32'd1);
    chk("fetch_en_nop", 32'(bus.Reg_File_En), 32'h0);

    // ADD R2,R1
    to_exec();
    chk("add_opcode", 32'(bus.Opcode), 32'h05);
    chk("add_rdest", 32'(bus.Rdest_mux_sel), 32'd2);
    chk("add_rsrc", 32'(bus.Rsrc_mux_sel), 32'd1);
    chk("add_isel", 32'(bus.Imm_mux_sel), 32'd0);
    chk("add_en", 32'(bus.Reg_File_En), 32'h0004);
    tick();

    // CMP R0,R1
    to_exec();
    chk("cmp_opcode", 32'(bus.Opcode), 32'h0B);
    chk("cmp_en", 32'(bus.Reg_File_En), 32'h0000);
    tick();

    // SUBI R4,0xFF (sign-extended)
    to_exec();
    chk("subi_imm", 32'(bus.Imm_val), 32'hFFFF);
    chk("subi_opcode", 32'(bus.Opcode), 32'h90);
    chk("subi_en", 32'(bus.Reg_File_En), 32'h0010);
    chk("subi_rsrc", 32'(bus.Rsrc_mux_sel), 32'd4);
    tick();

    // ANDI R3,0xFF (zero-extended)
    to_exec();
    chk("andi_imm", 32'(bus.Imm_val), 32'h00FF);
    chk("andi_opcode", 32'(bus.Opcode), 32'h10);
    tick();

    // Shift ext 1 on R3 by 2
    to_exec();
    chk("shf_opcode", 32'(bus.Opcode), 32'h81);
    chk("shf_imm", 32'(bus.Imm_val), 32'h0002);
    chk("shf_isel", 32'(bus.Imm_mux_sel), 32'd0);
    chk("shf_en", 32'(bus.Reg_File_En), 32'h0008);
    tick();
    chk("shf_next", 32'(bus.Mem_addr), 32'd6);

    // Branch / illegal / halt program
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    mem[5] = 16'hC0FE;
    mem[7] = 16'h4000;
    mem[8] = 16'hF000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_addr", 32'(bus.Mem_addr), 32'd0);
    nop_run(5);
    chk("pre_beq_addr", 32'(bus.Mem_addr), 32'd5);
    bus.Flags = 5'b00010;
    to_exec();
    chk("beq_en", 32'(bus.Reg_File_En), 32'h0);
    tick();
    chk("beq_taken", 32'(bus.Mem_addr), 32'd3);
    nop_run(2);
    bus.Flags = 5'b00000;
    to_exec();
    tick();
    chk("beq_not_taken", 32'(bus.Mem_addr), 32'd6);
    nop_run(1);
    chk("pre_ill_addr", 32'(bus.Mem_addr), 32'd7);
    tick();
    chk("ill_pre_low", 32'(bus.Illegal), 32'd0);
    tick();
    chk("ill_high", 32'(bus.Illegal), 32'd1);
    chk("ill_en", 32'(bus.Reg_File_En), 32'h0);
    tick();
    chk("ill_low", 32'(bus.Illegal), 32'd0);
    chk("ill_next", 32'(bus.Mem_addr), 32'd8);
    to_exec();
    chk("halt_exec_halted", 32'(bus.Halted), 32'd0);
    tick();
    chk("halted", 32'(bus.Halted), 32'd1);
    any_rd = 1'b0;
    any_unhalt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.Mem_rd_en) any_rd = 1'b1;
      if (!bus.Halted) any_unhalt = 1'b1;
    end
    chk("halt_no_rd", 32'(any_rd), 32'd0);
    chk("halt_stays", 32'(any_unhalt), 32'd0);
    chk("halt_pc", 32'(bus.Mem_addr), 32'd8);

    // Reset from S_HALT; next program is UC -1 at 0 and UC +1 at the top address
    mem[0] = 16'hCEFF;
    mem[(1 << AW) - 1] = 16'hCE01;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hrst_addr", 32'(bus.Mem_addr), 32'd0);
    chk("hrst_rd_en", 32'(bus.Mem_rd_en), 32'd1);
    chk("hrst_halted", 32'(bus.Halted), 32'd0);
    chk("hrst_opcode", 32'(bus.Opcode), 32'h00);
    chk("hrst_isel", 32'(bus.Imm_mux_sel), 32'd0);
    chk("hrst_en", 32'(bus.Reg_File_En), 32'h0);

    to_exec();
    tick();
    chk("uc_wrap_down", 32'(bus.Mem_addr), 32'h3FF);
    to_exec();
    chk("uc_opcode", 32'(bus.Opcode), 32'h00);
    tick();
    chk("uc_wrap_up", 32'(bus.Mem_addr), 32'd0);
    to_exec();
    tick();
    chk("uc_again", 32'(bus.Mem_addr), 32'h3FF);

    // Reset during S_WAIT
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wrst_addr", 32'(bus.Mem_addr), 32'd0);
    chk("wrst_rd_en", 32'(bus.Mem_rd_en), 32'd1);
    chk("wrst_halted", 32'(bus.Halted), 32'd0);
    chk("wrst_imm", 32'(bus.Imm_val), 32'h0);
    chk("wrst_rdest", 32'(bus.Rdest_mux_sel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
